quad_step_decoder: RTL



---
 rtl/quad_step_decoder_if.sv | 11 +
 rtl/quad_step_decoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder bus: encoder phases in, step/direction/error pulses out.
interface quad_step_decoder_if;
  logic enc_a;
  logic enc_b;
  logic step;
  logic up;
  logic err;

  modport master (output enc_a, enc_b, input step, up, err);
  modport slave  (input enc_a, enc_b, output step, up, err);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to step/direction decoder with synchroniser, glitch filter and INIT settle.
// Optional x1 mode (one step per full cycle, on entry to 00) when QUAD_X1_EN is defined.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  quad_step_decoder_if.slave bus
);

  localparam int CNT_W  = $clog2(FILT_LEN) + 1;
  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int SET_W  = $clog2(SETTLE + 1);

  typedef enum logic {INIT, TRACK} state_e;

  // Channel index 1 = A, 0 = B, so {A,B} packs naturally into [1:0].
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [CNT_W-1:0]       cnt_d  [2];
  logic [1:0]             enc_ab, sync_ab;
  logic [1:0]             filt_ab_q, filt_ab_d;
  logic [1:0]             prev_ab_q, prev_ab_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  state_e                 state_q, state_d;
  logic                   step_q, step_d;
  logic                   up_q, up_d;
  logic                   err_q, err_d;
  logic                   mv_legal, mv_up, mv_err;

  assign enc_ab  = {bus.enc_a, bus.enc_b};
  assign sync_ab = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  // Synchroniser shift and per-channel glitch filter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    filt_ab_d = filt_ab_q;
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], enc_ab[ch]};
      cnt_d[ch]  = cnt_q[ch];
      if (sync_ab[ch] == filt_ab_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_W'(FILT_LEN - 1)) begin
        filt_ab_d[ch] = sync_ab[ch];
        cnt_d[ch]     = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Transition classifier on {prev_ab, filt_ab}.
  always_comb begin
    mv_legal = 1'b0;
    mv_up    = 1'b0;
    mv_err   = 1'b0;
    case ({prev_ab_q, filt_ab_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: begin mv_legal = 1'b1; mv_up = 1'b1; end
      4'b0010, 4'b1011, 4'b1101, 4'b0100: begin mv_legal = 1'b1; mv_up = 1'b0; end
      4'b0011, 4'b0110, 4'b1001, 4'b1100: mv_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    prev_ab_d = filt_ab_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    up_d      = up_q;
    case (state_q)
      INIT: begin
        // Follow the next filtered value so the settled resting level is never decoded as a move.
        prev_ab_d = filt_ab_d;
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = TRACK;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      TRACK: begin
        err_d = mv_err;
`ifdef QUAD_X1_EN
        if (mv_legal && (filt_ab_q == 2'b00)) begin
          step_d = 1'b1;
          up_d   = mv_up;
        end
`else
        if (mv_legal) begin
          step_d = 1'b1;
          up_d   = mv_up;
        end
`endif
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      filt_ab_q <= 2'b00;
      prev_ab_q <= 2'b00;
      settle_q  <= '0;
      state_q   <= INIT;
      step_q    <= 1'b0;
      up_q      <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= sync_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
      end
      filt_ab_q <= filt_ab_d;
      prev_ab_q <= prev_ab_d;
      settle_q  <= settle_d;
      state_q   <= state_d;
      step_q    <= step_d;
      up_q      <= up_d;
      err_q     <= err_d;
    end
  end

  assign bus.step = step_q;
  assign bus.up   = up_q;
  assign bus.err  = err_q;

endmodule
